// File: rtl/bus_rr_xbar_if.sv
// bus_rr_xbar_if: host-side and device-side signal bundle of the shared-bus interconnect
interface bus_rr_xbar_if #(
   parameter int NrHosts      = 2,
   parameter int NrDevices    = 8,
   parameter int DataWidth    = 32,
   parameter int AddressWidth = 32
);
   logic [NrHosts-1:0]                     host_req;
   logic [NrHosts-1:0]                     host_we;
   logic [NrHosts-1:0][AddressWidth-1:0]   host_addr;
   logic [NrHosts-1:0][DataWidth/8-1:0]    host_be;
   logic [NrHosts-1:0][DataWidth-1:0]      host_wdata;
   logic [NrHosts-1:0]                     host_gnt;
   logic [NrHosts-1:0]                     host_rvalid;
   logic [NrHosts-1:0]                     host_err;
   logic [NrHosts-1:0][DataWidth-1:0]      host_rdata;
   logic [NrDevices-1:0]                   device_req;
   logic [NrDevices-1:0]                   device_we;
   logic [NrDevices-1:0][AddressWidth-1:0] device_addr;
   logic [NrDevices-1:0][DataWidth/8-1:0]  device_be;
   logic [NrDevices-1:0][DataWidth-1:0]    device_wdata;
   logic [NrDevices-1:0]                   device_rvalid;
   logic [NrDevices-1:0]                   device_err;
   logic [NrDevices-1:0][DataWidth-1:0]    device_rdata;
   logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_base;
   logic [NrDevices-1:0][AddressWidth-1:0] cfg_device_addr_mask;

   modport slave (
      input  host_req, host_we, host_addr, host_be, host_wdata,
      output host_gnt, host_rvalid, host_err, host_rdata,
      output device_req, device_we, device_addr, device_be, device_wdata,
      input  device_rvalid, device_err, device_rdata,
      input  cfg_device_addr_base, cfg_device_addr_mask
   );

   modport master (
      output host_req, host_we, host_addr, host_be, host_wdata,
      input  host_gnt, host_rvalid, host_err, host_rdata,
      input  device_req, device_we, device_addr, device_be, device_wdata,
      output device_rvalid, device_err, device_rdata,
      output cfg_device_addr_base, cfg_device_addr_mask
   );
endinterface

// File: rtl/bus_rr_xbar.sv
// bus_rr_xbar: round-robin shared-bus interconnect with base/mask decode, in-order pipelined responses and an ERR pseudo-device.
// Define BUS_HOST0_PRIORITY_EN to let host 0 win whenever it is eligible; the other hosts then round-robin among themselves.
module bus_rr_xbar #(
   parameter int NrHosts        = 2,
   parameter int NrDevices      = 8,
   parameter int DataWidth      = 32,
   parameter int AddressWidth   = 32,
   parameter int MaxOutstanding = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   bus_rr_xbar_if.slave bus
);
   localparam int DW = $clog2(NrDevices + 1);
   localparam int HW = NrHosts > 1 ? $clog2(NrHosts) : 1;
   localparam int PW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
   localparam int CW = $clog2(MaxOutstanding + 1);
   localparam logic [DW-1:0] Err = DW'(NrDevices);
`ifdef BUS_HOST0_PRIORITY_EN
   localparam bit Host0Prio = 1'b1;
`else
   localparam bit Host0Prio = 1'b0;
`endif

   logic [NrHosts-1:0][DW-1:0]         tgt;
   logic [NrHosts-1:0]                 elig;
   logic [HW-1:0]                      rr_ptr, sel;
   logic                               found, gnt;
   logic [DW-1:0]                      gtgt, cur_dev;
   logic [CW-1:0]                      out_cnt;
   logic                               err_pend;
   logic [HW-1:0]                      route [MaxOutstanding];
   logic [PW-1:0]                      wr_ptr, rd_ptr;
   logic [NrDevices:0]                 rv_ext, err_ext;
   logic [NrDevices:0][DataWidth-1:0]  rd_ext;
   logic                               rsp;
   logic [HW-1:0]                      rsp_host;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return p == PW'(MaxOutstanding - 1) ? '0 : p + 1'b1;
   endfunction

   // Lowest matching index wins, so scan downwards and let later hits overwrite.
   always_comb begin
      for (int h = 0; h < NrHosts; h++) begin
         tgt[h] = Err;
         for (int d = NrDevices - 1; d >= 0; d--)
            if ((bus.host_addr[h] & bus.cfg_device_addr_mask[d]) == bus.cfg_device_addr_base[d]) tgt[h] = DW'(d);
         elig[h] = bus.host_req[h] && out_cnt < CW'(MaxOutstanding) && (out_cnt == '0 || tgt[h] == cur_dev);
      end
   end

   // The first requester in round-robin order owns the bus slot; if it is not eligible it stalls in place.
   always_comb begin
      int j;
      j     = 0;
      sel   = '0;
      found = Host0Prio && elig[0];
      for (int i = 0; i < NrHosts; i++) begin
         j = (int'(rr_ptr) + i) % NrHosts;
         if (!found && bus.host_req[j] && !(Host0Prio && j == 0)) begin
            sel   = HW'(j);
            found = 1'b1;
         end
      end
      gnt  = found && elig[sel];
      gtgt = tgt[sel];
   end

   assign rv_ext   = {err_pend, bus.device_rvalid};
   assign err_ext  = {1'b1, bus.device_err};
   assign rd_ext   = {{DataWidth{1'b0}}, bus.device_rdata};
   assign rsp      = out_cnt != '0 && rv_ext[cur_dev];
   assign rsp_host = route[rd_ptr];

   always_comb begin
      for (int h = 0; h < NrHosts; h++) begin
         bus.host_gnt[h]    = gnt && sel == HW'(h);
         bus.host_rvalid[h] = rsp && rsp_host == HW'(h);
         bus.host_err[h]    = rsp && rsp_host == HW'(h) && err_ext[cur_dev];
         bus.host_rdata[h]  = rsp && rsp_host == HW'(h) ? rd_ext[cur_dev] : '0;
      end
      for (int d = 0; d < NrDevices; d++) begin
         bus.device_req[d]   = gnt && gtgt == DW'(d);
         bus.device_we[d]    = gnt && gtgt == DW'(d) && bus.host_we[sel];
         bus.device_addr[d]  = gnt ? bus.host_addr[sel] : '0;
         bus.device_be[d]    = gnt ? bus.host_be[sel] : '0;
         bus.device_wdata[d] = gnt ? bus.host_wdata[sel] : '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_cnt  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         rr_ptr   <= '0;
         cur_dev  <= '0;
         err_pend <= 1'b0;
      end else begin
         err_pend <= gnt && gtgt == Err;
         out_cnt  <= out_cnt + CW'(gnt) - CW'(rsp);
         if (gnt) begin
            route[wr_ptr] <= sel;
            wr_ptr        <= inc(wr_ptr);
            cur_dev       <= gtgt;
            if (!Host0Prio || sel != '0) rr_ptr <= sel == HW'(NrHosts - 1) ? '0 : sel + 1'b1;
         end
         if (rsp) rd_ptr <= inc(rd_ptr);
      end
   end
endmodule
